// File: rtl/v35_intc.sv
// V35-style external interrupt controller: edge-detected channels, per-channel ICR, priority-level in-service tracking.
// Define V35_INTC_SYNC_EN to add a two-flop synchronizer on the intp pins.
module v35_intc #(
  parameter int         NUM_IRQ  = 3,
  parameter int         VEC_BASE = 24,
  parameter logic [7:0] ICR_BASE = 8'h4C
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_cycle,
  input  logic [NUM_IRQ-1:0] intp,
  input  logic               sfr_wr,
  input  logic               sfr_rd,
  input  logic [7:0]         sfr_addr,
  input  logic [7:0]         sfr_din,
  output logic [7:0]         sfr_dout,
  output logic               irq_req,
  output logic [7:0]         irq_vec,
  input  logic               irq_ack,
  input  logic               irq_fini
);

  localparam logic [7:0] EMR_ADDR  = 8'h41;
  localparam logic [7:0] ISPR_ADDR = 8'hFC;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] flag_q, flag_d, mask_q, mask_d, emr_q, emr_d, prev_q, prev_d;
  logic [2:0]         pri_q [NUM_IRQ];
  logic [2:0]         pri_d [NUM_IRQ];
  logic [7:0]         ispr_q, ispr_d;
  logic [2:0]         ch_q, ch_d, lpri_q, lpri_d;
  logic [7:0]         vec_q, vec_d, dout_q, dout_d;

  logic [NUM_IRQ-1:0] pin_c, edge_c, elig_c, icr_sel_c;
  logic               ack_c, fini_c, found_c;
  logic [2:0]         best_pri_c, best_ch_c;
  logic [7:0]         rdata_c;

`ifdef V35_INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intp;
      sync2_q <= sync1_q;
    end
  end

  assign pin_c = sync2_q;
`else
  assign pin_c = intp;
`endif

  assign ack_c    = ce_cycle && irq_ack && (state_q == PEND);
  assign fini_c   = ce_cycle && irq_fini;
  assign edge_c   = ce_cycle ? ((pin_c ^ prev_q) & ~(pin_c ^ emr_q)) : '0;
  assign irq_req  = (state_q == PEND);
  assign irq_vec  = vec_q;
  assign sfr_dout = dout_q;

  // Eligibility excludes channels whose priority is at or below any level in service
  always_comb begin
    found_c    = 1'b0;
    best_pri_c = 3'd7;
    best_ch_c  = 3'd0;
    elig_c     = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      elig_c[n] = flag_q[n] && !mask_q[n] && ((ispr_q << (3'd7 - pri_q[n])) == 8'h00);
      if (elig_c[n] && (!found_c || (pri_q[n] < best_pri_c))) begin
        found_c    = 1'b1;
        best_pri_c = pri_q[n];
        best_ch_c  = 3'(n);
      end
    end
  end

  // SFR decode and read mux
  always_comb begin
    icr_sel_c = '0;
    rdata_c   = 8'h00;
    if (sfr_addr == EMR_ADDR)  rdata_c = 8'(emr_q);
    if (sfr_addr == ISPR_ADDR) rdata_c = ispr_q;
    for (int n = 0; n < NUM_IRQ; n++) begin
      icr_sel_c[n] = (sfr_addr == (ICR_BASE + 8'(n)));
      if (icr_sel_c[n]) rdata_c = {flag_q[n], mask_q[n], 3'b000, pri_q[n]};
    end
  end

  // Next state: hardware updates first, then SFR writes, then edge sets win last
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    mask_d  = mask_q;
    pri_d   = pri_q;
    emr_d   = emr_q;
    prev_d  = prev_q;
    ispr_d  = ispr_q;
    ch_d    = ch_q;
    lpri_d  = lpri_q;
    vec_d   = vec_q;
    dout_d  = dout_q;

    if (ce_cycle) prev_d = pin_c;
    if (fini_c)   ispr_d = ispr_d & (ispr_d - 8'd1);

    case (state_q)
      IDLE: begin
        if (ce_cycle && found_c) begin
          state_d = PEND;
          ch_d    = best_ch_c;
          lpri_d  = best_pri_c;
          vec_d   = 8'(VEC_BASE) + {5'd0, best_ch_c};
        end
      end
      PEND: begin
        if (ack_c) begin
          state_d         = IDLE;
          ispr_d[lpri_q]  = 1'b1;
          for (int n = 0; n < NUM_IRQ; n++) begin
            if (ch_q == 3'(n)) flag_d[n] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (sfr_wr) begin
      if (sfr_addr == EMR_ADDR)  emr_d  = sfr_din[NUM_IRQ-1:0];
      if (sfr_addr == ISPR_ADDR) ispr_d = sfr_din;
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (icr_sel_c[n]) begin
          flag_d[n] = sfr_din[7];
          mask_d[n] = sfr_din[6];
          pri_d[n]  = sfr_din[2:0];
        end
      end
    end

    flag_d = flag_d | edge_c;
    if (sfr_rd) dout_d = rdata_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flag_q  <= '0;
      mask_q  <= '1;
      for (int n = 0; n < NUM_IRQ; n++) pri_q[n] <= 3'd7;
      emr_q   <= '0;
      prev_q  <= '0;
      ispr_q  <= 8'h00;
      ch_q    <= 3'd0;
      lpri_q  <= 3'd0;
      vec_q   <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      mask_q  <= mask_d;
      pri_q   <= pri_d;
      emr_q   <= emr_d;
      prev_q  <= prev_d;
      ispr_q  <= ispr_d;
      ch_q    <= ch_d;
      lpri_q  <= lpri_d;
      vec_q   <= vec_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_v35_intc.sv
// Self-checking bench for v35_intc: register table plus interrupt flow sequences.
module tb_v35_intc;

  localparam logic [7:0] ICR0 = 8'h4C;
  localparam logic [7:0] ICR1 = 8'h4D;
  localparam logic [7:0] ICR2 = 8'h4E;
  localparam logic [7:0] EMR  = 8'h41;
  localparam logic [7:0] ISPR = 8'hFC;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_cycle;
  logic [2:0] intp;
  logic       sfr_wr, sfr_rd;
  logic [7:0] sfr_addr, sfr_din, sfr_dout;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic       irq_ack, irq_fini;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_exp[$];
  string      sb_name[$];
  logic       rd_d1 = 1'b0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  v35_intc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_cycle (ce_cycle),
    .intp     (intp),
    .sfr_wr   (sfr_wr),
    .sfr_rd   (sfr_rd),
    .sfr_addr (sfr_addr),
    .sfr_din  (sfr_din),
    .sfr_dout (sfr_dout),
    .irq_req  (irq_req),
    .irq_vec  (irq_vec),
    .irq_ack  (irq_ack),
    .irq_fini (irq_fini)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Read-data scoreboard: expectation queued at the strobe, compared one clk later
  always @(posedge clk) rd_d1 <= sfr_rd;

  always @(negedge clk) begin
    if (rd_d1) begin
      if (sb_exp.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk(sb_name.pop_front(), 32'(sfr_dout), 32'(sb_exp.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sfr_addr = a;
    sfr_din  = d;
    sfr_wr   = 1'b1;
    @(posedge clk);
    #1 sfr_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    sfr_addr = a;
    sfr_rd   = 1'b1;
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    @(posedge clk);
    #1 sfr_rd = 1'b0;
  endtask

  task automatic pulse(input logic ack, input logic fini);
    irq_ack  = ack;
    irq_fini = fini;
    @(posedge clk);
    #1;
    irq_ack  = 1'b0;
    irq_fini = 1'b0;
  endtask

  task automatic wait_req(input logic [7:0] vec, input string name);
    int n = 0;
    while (!irq_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_req"}, 32'(irq_req), 32'd1);
    chk({name, "_vec"}, 32'(irq_vec), 32'(vec));
  endtask

  initial begin
    reset_n  = 1'b0;
    ce_cycle = 1'b1;
    intp     = 3'b000;
    sfr_wr   = 1'b0;
    sfr_rd   = 1'b0;
    sfr_addr = 8'h00;
    sfr_din  = 8'h00;
    irq_ack  = 1'b0;
    irq_fini = 1'b0;

    tbl[0] = '{ICR0,  8'hFF, 8'hC7};
    tbl[1] = '{ICR1,  8'h45, 8'h45};
    tbl[2] = '{ICR2,  8'h7A, 8'h42};
    tbl[3] = '{8'h4F, 8'h55, 8'h00};
    tbl[4] = '{EMR,   8'hFF, 8'h07};
    tbl[5] = '{ISPR,  8'hA5, 8'hA5};
    tbl[6] = '{8'h00, 8'h12, 8'h00};
    tbl[7] = '{ISPR,  8'h00, 8'h00};
    tbl[8] = '{EMR,   8'h00, 8'h00};
    tbl[9] = '{ICR0,  8'h47, 8'h47};

    #12;
    chk("rst_req",  32'(irq_req),  32'd0);
    chk("rst_vec",  32'(irq_vec),  32'd0);
    chk("rst_dout", 32'(sfr_dout), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    rd(ICR0, 8'h47, "rst_icr0");
    rd(ICR2, 8'h47, "rst_icr2");
    rd(EMR,  8'h00, "rst_emr");
    rd(ISPR, 8'h00, "rst_ispr");

    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    chk("tbl_no_req", 32'(irq_req), 32'd0);

    // Rising edge on channel 0, ack, then end of service
    wr(EMR, 8'h01);
    wr(ICR0, 8'h03);
    intp = 3'b001;
    wait_req(8'd24, "a");
    pulse(1'b1, 1'b0);
    chk("a_req_off", 32'(irq_req), 32'd0);
    rd(ISPR, 8'h08, "a_ispr");
    rd(ICR0, 8'h03, "a_icr0");
    pulse(1'b0, 1'b1);
    rd(ISPR, 8'h00, "a_ispr_fini");

    // Equal priority tie on channels 1 and 2, second blocked until fini
    intp = 3'b000;
    cyc(1);
    intp = 3'b110;
    cyc(1);
    wr(EMR, 8'h00);
    wr(ICR0, 8'h47);
    wr(ICR1, 8'h02);
    wr(ICR2, 8'h02);
    intp = 3'b000;
    wait_req(8'd25, "b1");
    pulse(1'b1, 1'b0);
    cyc(3);
    chk("b_blocked", 32'(irq_req), 32'd0);
    pulse(1'b0, 1'b1);
    wait_req(8'd26, "b2");
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    rd(ISPR, 8'h00, "b_ispr");
    rd(ICR1, 8'h02, "b_icr1");
    rd(ICR2, 8'h02, "b_icr2");

    // Higher level in service blocks a lower-priority request
    wr(ISPR, 8'h04);
    wr(ICR0, 8'h85);
    cyc(4);
    chk("c_blocked", 32'(irq_req), 32'd0);
    pulse(1'b0, 1'b1);
    rd(ISPR, 8'h00, "c_ispr");
    wait_req(8'd24, "c");

    // Masking in PEND does not withdraw the request; ack needs ce_cycle
    wr(ICR0, 8'hC5);
    cyc(3);
    chk("d_hold", 32'(irq_req), 32'd1);
    ce_cycle = 1'b0;
    pulse(1'b1, 1'b0);
    ce_cycle = 1'b1;
    chk("d_ack_no_ce", 32'(irq_req), 32'd1);
    pulse(1'b1, 1'b0);
    chk("d_req_off", 32'(irq_req), 32'd0);
    rd(ISPR, 8'h20, "d_ispr");
    rd(ICR0, 8'h45, "d_icr0");
    pulse(1'b0, 1'b1);

    // Coincident ack and fini: clear then set
    wr(ICR0, 8'h80);
    wait_req(8'd24, "e");
    wr(ISPR, 8'h01);
    pulse(1'b1, 1'b1);
    rd(ISPR, 8'h01, "e_ispr");
    rd(ICR0, 8'h00, "e_icr0");
    pulse(1'b0, 1'b1);
    chk("e_idle", 32'(irq_req), 32'd0);

    // Edge set coinciding with ack clear keeps the flag
    wr(EMR, 8'h01);
    intp = 3'b001;
    wait_req(8'd24, "f1");
    intp = 3'b000;
    cyc(1);
    intp = 3'b001;
    pulse(1'b1, 1'b0);
    chk("f_req_off", 32'(irq_req), 32'd0);
    rd(ICR0, 8'h80, "f_icr0");
    chk("f_blocked", 32'(irq_req), 32'd0);
    pulse(1'b0, 1'b1);
    wait_req(8'd24, "f2");
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    rd(ISPR, 8'h00, "f_ispr");

    // Reset while pending abandons the request
    wr(ICR0, 8'h80);
    wait_req(8'd24, "h");
    reset_n = 1'b0;
    #1;
    chk("h_req_rst",  32'(irq_req),  32'd0);
    chk("h_vec_rst",  32'(irq_vec),  32'd0);
    chk("h_dout_rst", 32'(sfr_dout), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    rd(ICR0, 8'h47, "h_icr0");
    rd(ISPR, 8'h00, "h_ispr");
    chk("h_req", 32'(irq_req), 32'd0);

    cyc(2);
    chk("sb_drain", 32'(sb_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
